// File: rtl/wb_ctrl_pkg.sv
// Load-queue entry layout, load opcodes and the load-result formatter.
package wb_ctrl_pkg;

  localparam logic [2:0] LSUOP_LB  = 3'b000;
  localparam logic [2:0] LSUOP_LH  = 3'b001;
  localparam logic [2:0] LSUOP_LW  = 3'b010;
  localparam logic [2:0] LSUOP_LBU = 3'b100;
  localparam logic [2:0] LSUOP_LHU = 3'b101;

  localparam int RD_W        = 5;
  localparam int LDQ_ENTRY_W = RD_W + 3 + 2;

  // rd sits in the MSBs so the FIFO can expose it as the visible tag.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [2:0]      lsuop;
    logic [1:0]      offset;
  } ldq_entry_t;

  // Extract and extend the addressed byte/half from the aligned memory word.
  // A halfword at offset 3 would straddle the word, so only the top byte is used.
  function automatic logic [31:0] ld_format_f(input logic [31:0] data,
                                              input logic [2:0]  lsuop,
                                              input logic [1:0]  offset);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    shifted = data >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = shifted[15:0];
    case (lsuop)
      LSUOP_LB:  res = {{24{b[7]}}, b};
      LSUOP_LBU: res = {24'h0, b};
      LSUOP_LH:  res = (offset == 2'd3) ? {{24{b[7]}}, b} : {{16{h[15]}}, h};
      LSUOP_LHU: res = (offset == 2'd3) ? {24'h0, b} : {16'h0, h};
      default:   res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_pkg.sv
// Writeback stage payload shared between the writeback controller and decode.
package wb_stage_pkg;

  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                     rf_en;
    logic [4:0]               rd;
    logic [WB_DATA_WIDTH-1:0] wb_data;
  } wb_stage_out_t;

endpackage

// File: rtl/ldq_fifo.sv
// Generic synchronous FIFO; also exposes the top VIS_W bits of every slot
// together with a per-slot valid mask so the owner can scan queued entries.
module ldq_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  parameter  int VIS_W = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*VIS_W-1:0] vis_out,
  output logic [DEPTH-1:0]       vis_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] age;
    age       = '0;
    vis_out   = '0;
    vis_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = PTR_W'(i) - rd_ptr;
      vis_valid[i] = ({1'b0, age} < count);
      vis_out[i*VIS_W +: VIS_W] = mem[i][WIDTH-1 -: VIS_W];
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: merges in-order ex results with in-order load
// responses into one registered register-file write per cycle and reports
// which registers still await a load.
import wb_stage_pkg::*;
import wb_ctrl_pkg::*;

module wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LDQ_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  ex_valid_in,
  output logic                  ex_ready_out,
  input  logic                  ex_rf_en_in,
  input  logic [4:0]            ex_rd_in,
  input  logic [DATA_WIDTH-1:0] ex_data_in,
  input  logic                  ld_issue_in,
  input  logic [4:0]            ld_rd_in,
  input  logic [2:0]            ld_lsuop_in,
  input  logic [1:0]            ld_offset_in,
  output logic                  ld_full_out,
  input  logic                  dm_rsp_valid_in,
  input  logic [DATA_WIDTH-1:0] dm_rsp_data_in,
  output wb_stage_out_t         wb_out,
  output logic [31:0]           pending_out
);

  localparam int CNT_W = $clog2(LDQ_DEPTH) + 1;

  ldq_entry_t                  ld_push_entry;
  ldq_entry_t                  ld_head;
  logic                        ld_full;
  logic                        ld_empty;
  logic [CNT_W-1:0]            ld_count;
  logic [LDQ_DEPTH*RD_W-1:0]   vis_rd;
  logic [LDQ_DEPTH-1:0]        vis_valid;
  logic                        ld_push;
  logic                        rsp_take;
  logic                        ex_acc;

  logic                        hold_valid;
  logic                        hold_rf_en;
  logic [4:0]                  hold_rd;
  logic [DATA_WIDTH-1:0]       hold_data;
  logic                        wb_is_load;

  logic                        sel_valid;
  logic                        sel_load;
  logic                        sel_rf_en;
  logic [4:0]                  sel_rd;
  logic [DATA_WIDTH-1:0]       sel_data;
  logic                        hold_load;
  logic                        hold_drain;
  logic [31:0]                 pending;

  assign ld_push_entry = '{rd: ld_rd_in, lsuop: ld_lsuop_in, offset: ld_offset_in};
  assign ld_push       = ld_issue_in & ~ld_full;
  assign rsp_take      = dm_rsp_valid_in & ~ld_empty;
  assign ex_ready_out  = ~hold_valid;
  assign ex_acc        = ex_valid_in & ex_ready_out;
  assign ld_full_out   = (ld_count == CNT_W'(LDQ_DEPTH));
  assign pending_out   = pending;

  ldq_fifo #(
    .WIDTH (LDQ_ENTRY_W),
    .DEPTH (LDQ_DEPTH),
    .VIS_W (RD_W)
  ) u_ldq (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (ld_push),
    .pop       (rsp_take),
    .din       (ld_push_entry),
    .dout      (ld_head),
    .full      (ld_full),
    .empty     (ld_empty),
    .count     (ld_count),
    .vis_out   (vis_rd),
    .vis_valid (vis_valid)
  );

  // Write source select: load response beats the held ex result beats a fresh ex result.
  always_comb begin
    sel_valid  = 1'b0;
    sel_load   = 1'b0;
    sel_rf_en  = 1'b0;
    sel_rd     = '0;
    sel_data   = '0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    if (rsp_take) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rf_en = 1'b1;
      sel_rd    = ld_head.rd;
      sel_data  = ld_format_f(dm_rsp_data_in, ld_head.lsuop, ld_head.offset);
      hold_load = ex_acc;
    end else if (hold_valid) begin
      sel_valid  = 1'b1;
      sel_rf_en  = hold_rf_en;
      sel_rd     = hold_rd;
      sel_data   = hold_data;
      hold_drain = 1'b1;
    end else if (ex_acc) begin
      sel_valid = 1'b1;
      sel_rf_en = ex_rf_en_in;
      sel_rd    = ex_rd_in;
      sel_data  = ex_data_in;
    end
  end

  // Registered writeback and the one-deep hold for an ex result displaced by a response.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wb_out     <= '0;
      wb_is_load <= 1'b0;
      hold_valid <= 1'b0;
      hold_rf_en <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else begin
      if (sel_valid) begin
        wb_out.rf_en   <= sel_rf_en & (sel_rd != 5'd0);
        wb_out.rd      <= sel_rd;
        wb_out.wb_data <= sel_data;
      end else begin
        wb_out.rf_en <= 1'b0;
      end
      wb_is_load <= sel_valid & sel_load;
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_rf_en <= ex_rf_en_in;
        hold_rd    <= ex_rd_in;
        hold_data  <= ex_data_in;
      end else if (hold_drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Pending mask: queued load destinations plus a load write still on wb_out.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (vis_valid[i]) pending[vis_rd[i*RD_W +: RD_W]] = 1'b1;
    end
    if (wb_is_load && wb_out.rf_en) pending[wb_out.rd] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;
  import wb_stage_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          ex_valid_in, ex_rf_en_in;
  logic [4:0]    ex_rd_in;
  logic [DW-1:0] ex_data_in;
  logic          ex_ready_out;
  logic          ld_issue_in;
  logic [4:0]    ld_rd_in;
  logic [2:0]    ld_lsuop_in;
  logic [1:0]    ld_offset_in;
  logic          ld_full_out;
  logic          dm_rsp_valid_in;
  logic [DW-1:0] dm_rsp_data_in;
  wb_stage_out_t wb_out;
  logic [31:0]   pending_out;

  always #5 clk = ~clk;

  wb_ctrl #(.DATA_WIDTH(DW), .LDQ_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .ex_valid_in     (ex_valid_in),
    .ex_ready_out    (ex_ready_out),
    .ex_rf_en_in     (ex_rf_en_in),
    .ex_rd_in        (ex_rd_in),
    .ex_data_in      (ex_data_in),
    .ld_issue_in     (ld_issue_in),
    .ld_rd_in        (ld_rd_in),
    .ld_lsuop_in     (ld_lsuop_in),
    .ld_offset_in    (ld_offset_in),
    .ld_full_out     (ld_full_out),
    .dm_rsp_valid_in (dm_rsp_valid_in),
    .dm_rsp_data_in  (dm_rsp_data_in),
    .wb_out          (wb_out),
    .pending_out     (pending_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of outstanding loads, one held ex result, last write.
  typedef struct {
    logic [4:0] rd;
    logic [2:0] op;
    logic [1:0] off;
  } ld_t;

  ld_t         q[$];
  bit          m_hold_v;
  logic        m_hold_en;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  logic        m_rf_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_is_load;

  function automatic logic [31:0] fmt(input logic [31:0] data, input logic [2:0] op, input logic [1:0] off);
    logic [31:0] b, h;
    b = (data >> (8 * off)) & 32'hFF;
    h = (off == 2'd3) ? b : ((data >> (8 * off)) & 32'hFFFF);
    case (op)
      3'b000: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b100: return b;
      3'b001: begin
        if (off == 2'd3) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      end
      3'b101: return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) p[q[i].rd] = 1'b1;
    if (m_is_load && m_rf_en) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_hold_v  = 0;
    m_hold_en = 0; m_hold_rd = '0; m_hold_data = '0;
    m_rf_en   = 0; m_rd = '0; m_data = '0; m_is_load = 0;
  endtask

  task automatic idle();
    ex_valid_in = 0; ex_rf_en_in = 0; ex_rd_in = '0; ex_data_in = '0;
    ld_issue_in = 0; ld_rd_in = '0; ld_lsuop_in = '0; ld_offset_in = '0;
    dm_rsp_valid_in = 0; dm_rsp_data_in = '0;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic [31:0] d);
    ex_valid_in = 1; ex_rf_en_in = 1; ex_rd_in = rd; ex_data_in = d;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] off);
    ld_issue_in = 1; ld_rd_in = rd; ld_lsuop_in = op; ld_offset_in = off;
  endtask

  task automatic set_rsp(input logic [31:0] d);
    dm_rsp_valid_in = 1; dm_rsp_data_in = d;
  endtask

  // One clock with the currently driven inputs; checks before and after the edge.
  task automatic cycle();
    bit  take, acc, push;
    ld_t e;
    #1;
    check("ex_ready", {31'b0, ex_ready_out}, {31'b0, !m_hold_v});
    check("ld_full", {31'b0, ld_full_out}, {31'b0, q.size() == DEPTH});
    take = dm_rsp_valid_in && q.size() > 0;
    acc  = ex_valid_in && !m_hold_v;
    push = ld_issue_in && q.size() < DEPTH;
    @(posedge clk);
    if (take) begin
      e         = q.pop_front();
      m_rd      = e.rd;
      m_data    = fmt(dm_rsp_data_in, e.op, e.off);
      m_rf_en   = (e.rd != 0);
      m_is_load = 1;
      if (acc) begin
        m_hold_v = 1; m_hold_en = ex_rf_en_in; m_hold_rd = ex_rd_in; m_hold_data = ex_data_in;
      end
    end else if (m_hold_v) begin
      m_rd = m_hold_rd; m_data = m_hold_data; m_rf_en = m_hold_en && (m_hold_rd != 0);
      m_is_load = 0; m_hold_v = 0;
    end else if (acc) begin
      m_rd = ex_rd_in; m_data = ex_data_in; m_rf_en = ex_rf_en_in && (ex_rd_in != 0);
      m_is_load = 0;
    end else begin
      m_rf_en = 0; m_is_load = 0;
    end
    if (push) begin
      e.rd = ld_rd_in; e.op = ld_lsuop_in; e.off = ld_offset_in;
      q.push_back(e);
    end
    #1;
    check("wb_rf_en", {31'b0, wb_out.rf_en}, {31'b0, m_rf_en});
    check("wb_rd", {27'b0, wb_out.rd}, {27'b0, m_rd});
    check("wb_data", wb_out.wb_data, m_data);
    check("pending", pending_out, model_pending());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ops [5];
    logic [2:0] op;
    logic [1:0] off;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;

    idle();
    model_reset();
    #12;
    check("rst_wb", wb_out, '0);
    check("rst_ready", {31'b0, ex_ready_out}, 32'd1);
    check("rst_full", {31'b0, ld_full_out}, 32'd0);
    check("rst_pending", pending_out, 32'd0);
    arst_n = 1;
    @(posedge clk); #1;

    // ex only
    set_ex(5'd5, 32'h1234); cycle(); idle();
    check("t1_rf_en", {31'b0, wb_out.rf_en}, 32'd1);
    check("t1_rd", {27'b0, wb_out.rd}, 32'd5);
    check("t1_data", wb_out.wb_data, 32'h1234);
    check("t1_ready", {31'b0, ex_ready_out}, 32'd1);
    cycle();

    // LB sign extension and pending lifetime
    set_ld(5'd7, 3'b000, 2'd2); cycle(); idle();
    check("t2_pend_issue", {31'b0, pending_out[7]}, 32'd1);
    cycle(); cycle();
    set_rsp(32'h0080_0000); cycle(); idle();
    check("t2_data", wb_out.wb_data, 32'hFFFF_FF80);
    check("t2_pend_wr", {31'b0, pending_out[7]}, 32'd1);
    cycle();
    check("t2_pend_clr", {31'b0, pending_out[7]}, 32'd0);

    // response and ex in the same cycle
    set_ld(5'd3, 3'b010, 2'd0); cycle(); idle();
    set_rsp(32'hA); set_ex(5'd4, 32'hB); cycle(); idle();
    check("t3_rd1", {27'b0, wb_out.rd}, 32'd3);
    check("t3_data1", wb_out.wb_data, 32'hA);
    check("t3_ready1", {31'b0, ex_ready_out}, 32'd0);
    cycle();
    check("t3_rd2", {27'b0, wb_out.rd}, 32'd4);
    check("t3_data2", wb_out.wb_data, 32'hB);
    check("t3_ready2", {31'b0, ex_ready_out}, 32'd1);

    // fill queue, drop fifth, drain in order, pop on empty
    for (int i = 0; i < 4; i++) begin
      set_ld(5'(10 + i), 3'b010, 2'd0); cycle();
    end
    idle();
    check("t4_full", {31'b0, ld_full_out}, 32'd1);
    set_ld(5'd14, 3'b010, 2'd0); cycle(); idle();
    for (int i = 0; i < 4; i++) begin
      set_rsp(32'(100 + i)); cycle();
      check("t4_order", {27'b0, wb_out.rd}, 32'(10 + i));
    end
    check("t4_empty_full", {31'b0, ld_full_out}, 32'd0);
    cycle();
    check("t4_pop_empty", {31'b0, wb_out.rf_en}, 32'd0);
    idle();

    // duplicate rd and load to x0
    set_ld(5'd9, 3'b010, 2'd0); cycle();
    set_ld(5'd9, 3'b010, 2'd0); cycle(); idle();
    set_rsp(32'h11); cycle(); idle();
    cycle();
    check("t5_dup_held", {31'b0, pending_out[9]}, 32'd1);
    set_rsp(32'h22); cycle(); idle();
    cycle();
    check("t5_dup_clr", {31'b0, pending_out[9]}, 32'd0);
    set_ld(5'd0, 3'b010, 2'd0); cycle(); idle();
    check("t5_x0_pend", pending_out, 32'd0);
    set_rsp(32'h33); cycle(); idle();
    check("t5_x0_rf_en", {31'b0, wb_out.rf_en}, 32'd0);

    // reset with queued loads and a held result
    for (int i = 0; i < 4; i++) begin
      set_ld(5'(20 + i), 3'b010, 2'd0); cycle();
    end
    idle();
    set_rsp(32'h44); set_ex(5'd6, 32'h55); cycle(); idle();
    check("t6_hold", {31'b0, ex_ready_out}, 32'd0);
    arst_n = 0;
    #1;
    model_reset();
    check("t6_wb", wb_out, '0);
    check("t6_ready", {31'b0, ex_ready_out}, 32'd1);
    check("t6_full", {31'b0, ld_full_out}, 32'd0);
    check("t6_pending", pending_out, 32'd0);
    #2 arst_n = 1;
    @(posedge clk); #1;
    set_rsp(32'h66); cycle(); idle();
    check("t6_no_write", {31'b0, wb_out.rf_en}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      idle();
      if ($urandom_range(0, 99) < 50) begin
        ex_valid_in = 1;
        ex_rf_en_in = ($urandom_range(0, 9) != 0);
        ex_rd_in    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ex_data_in  = $urandom;
      end
      if ($urandom_range(0, 99) < 40) begin
        op = ops[$urandom_range(0, 4)];
        if (op == 3'b010) off = 2'd0;
        else if (op == 3'b001 || op == 3'b101) off = 2'($urandom_range(0, 1) * 2);
        else off = 2'($urandom_range(0, 3));
        set_ld(($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15)), op, off);
      end
      if ($urandom_range(0, 99) < 40) set_rsp($urandom);
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
